// File: rtl/vga_sig_gen_if.sv
// rtl/vga_sig_gen_if.sv - frame-buffer read port, colour config and VGA output bundle
interface vga_sig_gen_if;
  logic [15:0] CONFIG_COLOURS;
  logic [14:0] VGA_ADDR;
  logic        VGA_DATA;
  logic        VGA_HS;
  logic        VGA_VS;
  logic [7:0]  VGA_COLOUR;
  logic        FRAME_START;

  modport master (
    input  CONFIG_COLOURS,
    input  VGA_DATA,
    output VGA_ADDR,
    output VGA_HS,
    output VGA_VS,
    output VGA_COLOUR,
    output FRAME_START
  );

  modport slave (
    output CONFIG_COLOURS,
    output VGA_DATA,
    input  VGA_ADDR,
    input  VGA_HS,
    input  VGA_VS,
    input  VGA_COLOUR,
    input  FRAME_START
  );
endinterface

// File: rtl/vga_sig_gen.sv
// rtl/vga_sig_gen.sv - VGA scan generator reading a 1-bit frame buffer at 4x4 pixel scale
module vga_sig_gen #(
  parameter int CLK_DIV = 4,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic          CLK,
  input  logic          RESETN,
  vga_sig_gen_if.master vga
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam logic [1:0] DIV_MAX  = 2'(CLK_DIV - 1);
  localparam logic [9:0] HC_LAST  = 10'(H_TOT - 1);
  localparam logic [9:0] VC_LAST  = 10'(V_TOT - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);

  logic [1:0]  div;
  logic [9:0]  hc;
  logic [9:0]  vc;
  logic [7:0]  fg;
  logic [7:0]  bg;
  logic [14:0] addr_q;
  logic        hs_q;
  logic        vs_q;
  logic [7:0]  colour_q;
  logic        frame_start_q;

  logic tick;
  logic hc_wrap;
  logic vc_wrap;
  logic visible;
  logic hsync_on;
  logic vsync_on;

  always_comb begin
    tick     = (div == DIV_MAX);
    hc_wrap  = (hc == HC_LAST);
    vc_wrap  = (vc == VC_LAST);
    visible  = (hc < 10'(H_VIS)) && (vc < 10'(V_VIS));
    hsync_on = (hc >= HS_FIRST) && (hc < HS_END);
    vsync_on = (vc >= VS_FIRST) && (vc < VS_END);
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      div           <= '0;
      hc            <= '0;
      vc            <= '0;
      fg            <= 8'hFF;
      bg            <= 8'h00;
      addr_q        <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      colour_q      <= '0;
      frame_start_q <= 1'b0;
    end else begin
      div           <= tick ? '0 : div + 2'd1;
      addr_q        <= visible ? {vc[8:2], hc[9:2]} : '0;
      frame_start_q <= tick && hc_wrap && vc_wrap;
      if (tick) begin
        hc <= hc_wrap ? '0 : hc + 10'd1;
        if (hc_wrap) begin
          vc <= vc_wrap ? '0 : vc + 10'd1;
        end
        // Colours only change at the frame boundary so an update never tears the image.
        if (hc_wrap && vc_wrap) begin
          fg <= vga.CONFIG_COLOURS[15:8];
          bg <= vga.CONFIG_COLOURS[7:0];
        end
        // Sync and colour come from the pixel being left, so all three share one stage.
        hs_q     <= !hsync_on;
        vs_q     <= !vsync_on;
        colour_q <= visible ? (vga.VGA_DATA ? fg : bg) : '0;
      end
    end
  end

  assign vga.VGA_ADDR    = addr_q;
  assign vga.VGA_HS      = hs_q;
  assign vga.VGA_VS      = vs_q;
  assign vga.VGA_COLOUR  = colour_q;
  assign vga.FRAME_START = frame_start_q;

endmodule
